// File: rtl/gen_param_loader_pkg.sv
// Shared definitions for the generator parameter loader.
//
// Holds the generator dimension defaults, the frame length, the segment base
// offsets of each parameter group inside a frame, the loader state encoding
// and the segment select encoding used between the controller and the
// register banks.
package gen_param_loader_pkg;

    // Generator dimension defaults (2-3-9 network).
    localparam int GEN_WIDTH       = 32;
    localparam int GEN_N_INPUT     = 2;
    localparam int GEN_N_NEURON_L2 = 3;
    localparam int GEN_N_NEURON_L3 = 9;

    // Words per frame: two latent inputs, then L2 weights, L2 biases,
    // L3 weights, L3 biases.
    function automatic int calc_n_words(input int n_in, input int n_l2, input int n_l3);
        return 2 + n_in * n_l2 + n_l2 + n_l2 * n_l3 + n_l3;
    endfunction

    localparam int N_WORDS = calc_n_words(GEN_N_INPUT, GEN_N_NEURON_L2, GEN_N_NEURON_L3);
    localparam int CNT_W   = $clog2(N_WORDS);

    // Segment base offsets within a frame at the default dimensions.
    localparam int OFF_A   = 0;
    localparam int OFF_WL2 = OFF_A + 2;
    localparam int OFF_BL2 = OFF_WL2 + GEN_N_INPUT * GEN_N_NEURON_L2;
    localparam int OFF_WL3 = OFF_BL2 + GEN_N_NEURON_L2;
    localparam int OFF_BL3 = OFF_WL3 + GEN_N_NEURON_L2 * GEN_N_NEURON_L3;

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        SEG_A   = 3'd0,
        SEG_WL2 = 3'd1,
        SEG_BL2 = 3'd2,
        SEG_WL3 = 3'd3,
        SEG_BL3 = 3'd4
    } seg_e;

endpackage

// File: rtl/gen_param_ctrl.sv
// Frame controller for the generator parameter loader.
//
// Tracks the word position within a frame, checks frame length against
// s_last, and decodes the word position into a segment select plus element
// index for the register banks. Also owns the LOAD/HOLD state.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   s_valid      upstream word valid
//   s_last       upstream end-of-frame marker
//   s_ready      loader accepts a word this cycle (registered)
//   frame_done   consumer releases the held parameter set
//   wr_en        write the current word into the bank chosen by seg/idx
//   seg, idx     destination segment and element within that segment
//   state_o      current LOAD/HOLD state (also drives params_valid)
//   err_len      sticky frame-length error
//
// Handshake: a word transfers on a rising edge where s_valid && s_ready.
// s_ready never depends on s_valid; s_valid may be withheld for any number
// of cycles and the word position simply holds.
module gen_param_ctrl
    import gen_param_loader_pkg::*;
#(
    parameter int N_INPUT     = GEN_N_INPUT,
    parameter int N_NEURON_L2 = GEN_N_NEURON_L2,
    parameter int N_NEURON_L3 = GEN_N_NEURON_L3,
    parameter int CW          = $clog2(calc_n_words(N_INPUT, N_NEURON_L2, N_NEURON_L3))
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    input  logic          frame_done,
    output logic          wr_en,
    output seg_e          seg,
    output logic [CW-1:0] idx,
    output state_e        state_o,
    output logic          err_len
);

    localparam int NW     = calc_n_words(N_INPUT, N_NEURON_L2, N_NEURON_L3);
    localparam int L_WL2  = 2;
    localparam int L_BL2  = L_WL2 + N_INPUT * N_NEURON_L2;
    localparam int L_WL3  = L_BL2 + N_NEURON_L2;
    localparam int L_BL3  = L_WL3 + N_NEURON_L2 * N_NEURON_L3;

    localparam logic [CW-1:0] WL2_C  = CW'(L_WL2);
    localparam logic [CW-1:0] BL2_C  = CW'(L_BL2);
    localparam logic [CW-1:0] WL3_C  = CW'(L_WL3);
    localparam logic [CW-1:0] BL3_C  = CW'(L_BL3);
    localparam logic [CW-1:0] LAST_C = CW'(NW - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          hs;
    logic          last_word;

    assign hs        = s_valid && ready_q;
    assign last_word = (cnt_q == LAST_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (state_q)
            LOAD: begin
                if (hs) begin
                    if (last_word) begin
                        // Final word is always accepted; a missing s_last
                        // only flags the error.
                        wr_en   = 1'b1;
                        cnt_d   = '0;
                        state_d = HOLD;
                        if (!s_last) begin
                            err_d = 1'b1;
                        end
                    end else if (s_last) begin
                        // Early end of frame: drop the word and resync so
                        // the next word is taken as a_1.
                        cnt_d = '0;
                        err_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (frame_done) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
        endcase
        // Registered ready: low in reset, low the cycle after the last word,
        // high the cycle after frame_done.
        ready_d = (state_d == LOAD);
    end

    always_comb begin
        seg = SEG_A;
        idx = cnt_q;
        if (cnt_q >= BL3_C) begin
            seg = SEG_BL3;
            idx = cnt_q - BL3_C;
        end else if (cnt_q >= WL3_C) begin
            seg = SEG_WL3;
            idx = cnt_q - WL3_C;
        end else if (cnt_q >= BL2_C) begin
            seg = SEG_BL2;
            idx = cnt_q - BL2_C;
        end else if (cnt_q >= WL2_C) begin
            seg = SEG_WL2;
            idx = cnt_q - WL2_C;
        end
    end

    assign s_ready = ready_q;
    assign state_o = state_q;
    assign err_len = err_q;

endmodule

// File: rtl/gen_param_loader.sv
// Parameter loader feeding the 2-3-9 generator datapath.
//
// Accepts a serial stream of signed WIDTH-bit words and writes each accepted
// word straight into its slot of the latent input, weight and bias registers.
// Once a full frame is in, the set is held stable with params_valid high
// until frame_done.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   s_data/s_valid/
//   s_last/s_ready      word stream (valid/ready)
//   a_1, a_2            latent inputs
//   w_L2, b_L2          layer-2 weights / biases, element k at [(k+1)*W-1:k*W]
//   w_L3, b_L3          layer-3 weights / biases, w_L3 element = 3*j + i
//   params_valid        full set loaded and stable
//   frame_done          consumer done with the set; resume loading
//   err_len             sticky frame-length error
module gen_param_loader
    import gen_param_loader_pkg::*;
#(
    parameter int WIDTH       = GEN_WIDTH,
    parameter int N_INPUT     = GEN_N_INPUT,
    parameter int N_NEURON_L2 = GEN_N_NEURON_L2,
    parameter int N_NEURON_L3 = GEN_N_NEURON_L3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic signed [WIDTH-1:0]              s_data,
    input  logic                                 s_valid,
    input  logic                                 s_last,
    output logic                                 s_ready,
    output logic signed [WIDTH-1:0]              a_1,
    output logic signed [WIDTH-1:0]              a_2,
    output logic [N_INPUT*N_NEURON_L2*WIDTH-1:0]     w_L2,
    output logic [N_NEURON_L2*WIDTH-1:0]             b_L2,
    output logic [N_NEURON_L2*N_NEURON_L3*WIDTH-1:0] w_L3,
    output logic [N_NEURON_L3*WIDTH-1:0]             b_L3,
    output logic                                 params_valid,
    input  logic                                 frame_done,
    output logic                                 err_len
);

    localparam int CW      = $clog2(calc_n_words(N_INPUT, N_NEURON_L2, N_NEURON_L3));
    localparam int WL2_B   = N_INPUT * N_NEURON_L2 * WIDTH;
    localparam int BL2_B   = N_NEURON_L2 * WIDTH;
    localparam int WL3_B   = N_NEURON_L2 * N_NEURON_L3 * WIDTH;
    localparam int BL3_B   = N_NEURON_L3 * WIDTH;

    logic          wr_en;
    seg_e          seg;
    logic [CW-1:0] idx;
    state_e        state;

    gen_param_ctrl #(
        .N_INPUT     (N_INPUT),
        .N_NEURON_L2 (N_NEURON_L2),
        .N_NEURON_L3 (N_NEURON_L3),
        .CW          (CW)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .frame_done (frame_done),
        .wr_en      (wr_en),
        .seg        (seg),
        .idx        (idx),
        .state_o    (state),
        .err_len    (err_len)
    );

    logic [WIDTH-1:0] a_1_q, a_1_d;
    logic [WIDTH-1:0] a_2_q, a_2_d;
    logic [WL2_B-1:0] w_l2_q, w_l2_d;
    logic [BL2_B-1:0] b_l2_q, b_l2_d;
    logic [WL3_B-1:0] w_l3_q, w_l3_d;
    logic [BL3_B-1:0] b_l3_q, b_l3_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_1_q  <= '0;
            a_2_q  <= '0;
            w_l2_q <= '0;
            b_l2_q <= '0;
            w_l3_q <= '0;
            b_l3_q <= '0;
        end else begin
            a_1_q  <= a_1_d;
            a_2_q  <= a_2_d;
            w_l2_q <= w_l2_d;
            b_l2_q <= b_l2_d;
            w_l3_q <= w_l3_d;
            b_l3_q <= b_l3_d;
        end
    end

    // Only the addressed element changes; everything else keeps its value,
    // so a resynced partial frame leaves stale data behind until overwritten.
    always_comb begin
        a_1_d  = a_1_q;
        a_2_d  = a_2_q;
        w_l2_d = w_l2_q;
        b_l2_d = b_l2_q;
        w_l3_d = w_l3_q;
        b_l3_d = b_l3_q;
        if (wr_en) begin
            case (seg)
                SEG_A: begin
                    if (idx == '0) begin
                        a_1_d = s_data;
                    end else begin
                        a_2_d = s_data;
                    end
                end
                SEG_WL2: w_l2_d[int'(idx)*WIDTH +: WIDTH] = s_data;
                SEG_BL2: b_l2_d[int'(idx)*WIDTH +: WIDTH] = s_data;
                SEG_WL3: w_l3_d[int'(idx)*WIDTH +: WIDTH] = s_data;
                SEG_BL3: b_l3_d[int'(idx)*WIDTH +: WIDTH] = s_data;
                default: ;
            endcase
        end
    end

    assign a_1          = a_1_q;
    assign a_2          = a_2_q;
    assign w_L2         = w_l2_q;
    assign b_L2         = b_l2_q;
    assign w_L3         = w_l3_q;
    assign b_L3         = b_l3_q;
    assign params_valid = (state == HOLD);

endmodule
